// File: rtl/smi_axi_pkg.sv
// Shared types and default widths for the SMI SELF-to-AXI output buffer.
package smi_axi_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        EMPTY = 2'd1,
        ONE   = 2'd2,
        TWO   = 2'd3
    } smi_axi_buf_state_t;

    localparam int unsigned SMI_AXI_DATA_WIDTH        = 16;
    localparam int unsigned SMI_AXI_STALL_COUNT_WIDTH = 16;

endpackage

// File: rtl/smi_axi_output_buffer_if.sv
// Upstream SELF handshake plus downstream AXI-stream signals of the output buffer.
interface smi_axi_output_buffer_if
    import smi_axi_pkg::*;
#(
    parameter int unsigned DataWidth = SMI_AXI_DATA_WIDTH
);
    logic [DataWidth-1:0] dataIn;
    logic                 dataInValid;
    logic                 dataInStop;
    logic [DataWidth-1:0] axiDataOut;
    logic                 axiValid;
    logic                 axiReady;

    // master: the buffer itself; slave: the upstream producer and AXI sink around it
    modport master (
        input  dataIn, dataInValid, axiReady,
        output dataInStop, axiDataOut, axiValid
    );

    modport slave (
        output dataIn, dataInValid, axiReady,
        input  dataInStop, axiDataOut, axiValid
    );
endinterface

// File: rtl/smi_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module smi_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/smi_axi_output_buffer.sv
// Two-entry SELF-to-AXI skid buffer; every AXI-side output comes straight from a flop.
// Optional stall counter enabled by SMI_AXI_OUTPUT_BUFFER_STALL_COUNT_EN.
module smi_axi_output_buffer
    import smi_axi_pkg::*;
#(
    parameter int unsigned DataWidth       = SMI_AXI_DATA_WIDTH,
    parameter int unsigned StallCountWidth = SMI_AXI_STALL_COUNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       srst_n,
    smi_axi_output_buffer_if.master    bus,
    output logic [StallCountWidth-1:0] stallCount
);

    smi_axi_buf_state_t   state_q, state_d;
    logic [DataWidth-1:0] a_q, a_d;
    logic [DataWidth-1:0] b_q, b_d;
    logic                 axi_valid_q, axi_valid_d;
    logic                 stop_q, stop_d;
    logic                 push;
    logic                 pop;

    assign push = bus.dataInValid & ~stop_q;
    assign pop  = axi_valid_q & bus.axiReady;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q     <= INIT;
            a_q         <= '0;
            b_q         <= '0;
            axi_valid_q <= 1'b0;
            stop_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            axi_valid_q <= axi_valid_d;
            stop_q      <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:  state_d = EMPTY;
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop) begin
                    state_d = TWO;
                end else if (!push && pop) begin
                    state_d = EMPTY;
                end
            end
            TWO:   if (pop) state_d = ONE;
            default: state_d = INIT;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops together with it
    always_comb begin
        axi_valid_d = (state_d == ONE) || (state_d == TWO);
        stop_d      = (state_d == INIT) || (state_d == TWO);
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        case (state_q)
            EMPTY: if (push) a_d = bus.dataIn;
            ONE: begin
                if (push && pop) begin
                    a_d = bus.dataIn;
                end else if (push) begin
                    b_d = bus.dataIn;
                end
            end
            TWO:   if (pop) a_d = b_q;
            default: begin
                a_d = a_q;
                b_d = b_q;
            end
        endcase
    end

    assign bus.axiDataOut = a_q;
    assign bus.axiValid   = axi_valid_q;
    assign bus.dataInStop = stop_q;

`ifdef SMI_AXI_OUTPUT_BUFFER_STALL_COUNT_EN
    smi_sat_counter #(
        .Width(StallCountWidth)
    ) u_stall_cnt (
        .clk    (clk),
        .clr_n_i(srst_n),
        .inc_i  (axi_valid_q & ~bus.axiReady),
        .count_o(stallCount)
    );
`else
    assign stallCount = '0;
`endif

endmodule
